// File: rtl/park_transform.sv
// Forward Park transform: (alpha, beta) -> (d, q) over a shared
// signed multiplier, four products per transaction, saturating outputs.
module park_transform #(
   parameter int D_WIDTH = 32,
   parameter int Q_BITS  = 10
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      start,
   input  logic signed [D_WIDTH-1:0] alpha,
   input  logic signed [D_WIDTH-1:0] beta,
   input  logic signed [D_WIDTH-1:0] sin,
   input  logic signed [D_WIDTH-1:0] cos,
   output logic                      busy,
   output logic signed [D_WIDTH-1:0] d,
   output logic signed [D_WIDTH-1:0] q,
   output logic                      sat,
   output logic                      done
);

   localparam int AW = 2*D_WIDTH + 1;
   localparam logic signed [AW-1:0] MAXV =
      {{(D_WIDTH+2){1'b0}}, {(D_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV =
      {{(D_WIDTH+2){1'b1}}, {(D_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic signed [D_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
   logic signed [D_WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
   logic signed [AW-1:0] accd_q, accd_d, accq_q, accq_d;
   logic signed [D_WIDTH-1:0] d_q, d_d, q_q, q_d;
   logic sat_q, sat_d, done_q, done_d;

   logic signed [D_WIDTH-1:0] mul_a, mul_b;
   logic signed [2*D_WIDTH-1:0] prod;
   logic signed [AW-1:0] prod_x, shd, shq;
   logic sat_dv, sat_qv;

   always_comb begin
      mul_a = alpha_q;
      mul_b = cos_q;
      unique case (cnt_q)
         2'd0: begin mul_a = alpha_q; mul_b = cos_q; end
         2'd1: begin mul_a = beta_q;  mul_b = sin_q; end
         2'd2: begin mul_a = beta_q;  mul_b = cos_q; end
         2'd3: begin mul_a = alpha_q; mul_b = sin_q; end
      endcase
   end

   // Operands sign-extended so the low 2*D_WIDTH bits are the exact product
   assign prod = {{D_WIDTH{mul_a[D_WIDTH-1]}}, mul_a}
               * {{D_WIDTH{mul_b[D_WIDTH-1]}}, mul_b};
   assign prod_x = {prod[2*D_WIDTH-1], prod};

   assign shd = accd_q >>> Q_BITS;
   assign shq = accq_q >>> Q_BITS;
   assign sat_dv = (shd > MAXV) || (shd < MINV);
   assign sat_qv = (shq > MAXV) || (shq < MINV);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      alpha_d = alpha_q;
      beta_d  = beta_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      accd_d  = accd_q;
      accq_d  = accq_q;
      d_d     = d_q;
      q_d     = q_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               alpha_d = alpha;
               beta_d  = beta;
               sin_d   = sin;
               cos_d   = cos;
               cnt_d   = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            cnt_d = cnt_q + 2'd1;
            unique case (cnt_q)
               2'd0: accd_d = prod_x;
               2'd1: accd_d = accd_q + prod_x;
               2'd2: accq_d = prod_x;
               2'd3: begin
                  accq_d  = accq_q - prod_x;
                  state_d = OUT;
               end
            endcase
         end
         OUT: begin
            if (shd > MAXV)      d_d = MAXV[D_WIDTH-1:0];
            else if (shd < MINV) d_d = MINV[D_WIDTH-1:0];
            else                 d_d = shd[D_WIDTH-1:0];
            if (shq > MAXV)      q_d = MAXV[D_WIDTH-1:0];
            else if (shq < MINV) q_d = MINV[D_WIDTH-1:0];
            else                 q_d = shq[D_WIDTH-1:0];
            sat_d   = sat_dv | sat_qv;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         alpha_q <= '0;
         beta_q  <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         accd_q  <= '0;
         accq_q  <= '0;
         d_q     <= '0;
         q_q     <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alpha_q <= alpha_d;
         beta_q  <= beta_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
         accd_q  <= accd_d;
         accq_q  <= accq_d;
         d_q     <= d_d;
         q_q     <= q_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign d    = d_q;
   assign q    = q_q;
   assign sat  = sat_q;
   assign done = done_q;

endmodule
